// File: rtl/keypad_entry_4x4.sv
// 4x4 matrix keypad scanner with frame debounce, single-press decode and a
// 4-digit decimal entry accumulator (digits, backspace, enter, clear).
module keypad_entry_4x4 #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [13:0] entry,
  output logic [2:0]  entry_cnt,
  output logic [13:0] value,
  output logic        value_valid
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_N     = 4'(DEBOUNCE_FRAMES);

  localparam logic [0:0] S_RELEASED = 1'b0;
  localparam logic [0:0] S_HELD     = 1'b1;

  localparam logic [3:0] K_CLR   = 4'd13;
  localparam logic [3:0] K_BKSP  = 4'd14;
  localparam logic [3:0] K_ENTER = 4'd15;

  // Physical position (row*4+col) to key code.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:  key_map = 4'd1;
      4'd1:  key_map = 4'd2;
      4'd2:  key_map = 4'd3;
      4'd3:  key_map = 4'd10;
      4'd4:  key_map = 4'd4;
      4'd5:  key_map = 4'd5;
      4'd6:  key_map = 4'd6;
      4'd7:  key_map = 4'd11;
      4'd8:  key_map = 4'd7;
      4'd9:  key_map = 4'd8;
      4'd10: key_map = 4'd9;
      4'd11: key_map = 4'd12;
      4'd12: key_map = K_BKSP;
      4'd13: key_map = 4'd0;
      4'd14: key_map = K_ENTER;
      default: key_map = K_CLR;
    endcase
  endfunction

  logic [3:0]       col_s1, col_s2;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [1:0]       row_sel;
  logic [15:0]      frame, frame_next, prev_frame, stable;
  logic [3:0]       db_cnt, db_cnt_next;
  logic             frame_done;
  logic [0:0]       state;
  logic [3:0]       key_idx;
  logic [16:0]      entry_x10;

  assign tick       = (div == DIV_LAST);
  assign frame_done = tick && (row_sel == 2'd3);

  always_comb begin
    frame_next = frame;
    frame_next[{row_sel, 2'b00} +: 4] = ~col_s2;
    if (frame_next == prev_frame)
      db_cnt_next = (db_cnt == 4'hF) ? 4'hF : db_cnt + 4'd1;
    else
      db_cnt_next = 4'd1;
  end

  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (stable[i]) key_idx = 4'(i);
  end

  assign entry_x10 = {3'b000, entry} * 17'd10 + {13'd0, key_code};

  // Scan, synchronizer and debounce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_s1     <= 4'b1111;
      col_s2     <= 4'b1111;
      div        <= '0;
      row_sel    <= 2'd0;
      row        <= 4'b1110;
      frame      <= '0;
      prev_frame <= '0;
      db_cnt     <= '0;
      stable     <= '0;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
      div    <= tick ? '0 : div + 1'b1;
      if (tick) begin
        frame   <= frame_next;
        row_sel <= row_sel + 2'd1;
        row     <= ~(4'b0001 << (row_sel + 2'd1));
      end
      if (frame_done) begin
        db_cnt <= db_cnt_next;
        if (frame_next != prev_frame) prev_frame <= frame_next;
        if (db_cnt_next >= DB_N) stable <= frame_next;
      end
    end
  end

  // Press FSM: one event per press, only for a clean single-key snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RELEASED;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        S_RELEASED:
          if (stable != '0) begin
            state <= S_HELD;
            if ($onehot(stable)) begin
              key_valid <= 1'b1;
              key_code  <= key_map(key_idx);
            end
          end
        default:
          if (stable == '0) state <= S_RELEASED;
      endcase
    end
  end

  // Entry accumulator, driven by the accepted key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry       <= '0;
      entry_cnt   <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (entry_cnt < 3'd4) begin
            entry     <= entry_x10[13:0];
            entry_cnt <= entry_cnt + 3'd1;
          end
        end else if (key_code == K_BKSP) begin
          if (entry_cnt != 3'd0) begin
            entry     <= entry / 14'd10;
            entry_cnt <= entry_cnt - 3'd1;
          end
        end else if (key_code == K_ENTER) begin
          if (entry_cnt != 3'd0) begin
            value       <= entry;
            value_valid <= 1'b1;
            entry       <= '0;
            entry_cnt   <= '0;
          end
        end else if (key_code == K_CLR) begin
          entry     <= '0;
          entry_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_4x4.sv
// Directed bench for keypad_entry_4x4: a keypad matrix model drives col from
// row and the set of held keys; each scenario task checks its own results.
module tb_keypad_entry_4x4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [13:0] entry;
  logic [2:0]  entry_cnt;
  logic [13:0] value;
  logic        value_valid;

  logic [15:0] keys = '0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0, kv_cnt = 0, vv_cnt = 0, kv_cyc = 0, vv_cyc = 0;
  logic [3:0] last_code = '0;

  keypad_entry_4x4 #(.SCAN_DIV(8), .DEBOUNCE_FRAMES(4)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid),
    .entry(entry), .entry_cnt(entry_cnt),
    .value(value), .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  // Key (r,c) shorts column c low while row r is driven low.
  always_comb begin
    col = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (key_valid === 1'b1) begin
      kv_cnt    <= kv_cnt + 1;
      kv_cyc    <= cyc;
      last_code <= key_code;
    end
    if (value_valid === 1'b1) begin
      vv_cnt <= vv_cnt + 1;
      vv_cyc <= cyc;
    end
  end

  task automatic press(input int idx);
    keys = 16'h0001 << idx;
    repeat (300) @(negedge clk);
    keys = '0;
    repeat (300) @(negedge clk);
  endtask

  task automatic chk_entry(input string nm, input int e, input int n);
    n_cmp++;
    if (entry !== 14'(e) || entry_cnt !== 3'(n)) begin
      n_err++;
      $display("FAIL %s: entry=%0d cnt=%0d expected entry=%0d cnt=%0d", nm, entry, entry_cnt, e, n);
    end
  endtask

  task automatic test_reset;
    int kv0, vv0;
    logic [3:0] exp_row;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (row !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 || entry !== 14'd0 ||
        entry_cnt !== 3'd0 || value !== 14'd0 || value_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: row=%b kv=%b kc=%0d entry=%0d cnt=%0d value=%0d vv=%b expected row=1110 all else 0",
               row, key_valid, key_code, entry, entry_cnt, value, value_valid);
    end
    kv0 = kv_cnt; vv0 = vv_cnt;
    rst_n = 1'b1;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << (((j + 1) / 8) % 4));
      n_cmp++;
      if (row !== exp_row) begin
        n_err++;
        $display("FAIL scan_row[%0d]: row=%b expected %b", j, row, exp_row);
      end
    end
    n_cmp++;
    if (kv_cnt != kv0 || vv_cnt != vv0 || entry !== 14'd0 || value !== 14'd0) begin
      n_err++;
      $display("FAIL idle_quiet: kv_pulses=%0d vv_pulses=%0d entry=%0d value=%0d expected 0 0 0 0",
               kv_cnt - kv0, vv_cnt - vv0, entry, value);
    end
  endtask

  task automatic test_bounce_hold;
    int kv0;
    kv0 = kv_cnt;
    keys = 16'h0020; repeat (8) @(negedge clk);
    keys = 16'h0000; repeat (8) @(negedge clk);
    keys = 16'h0020; repeat (8) @(negedge clk);
    repeat (300) @(negedge clk);
    n_cmp++;
    if (kv_cnt - kv0 != 1 || last_code !== 4'd5) begin
      n_err++;
      $display("FAIL bounce_press: pulses=%0d code=%0d expected 1 pulse code=5", kv_cnt - kv0, last_code);
    end
    chk_entry("bounce_entry", 5, 1);
    repeat (640) @(negedge clk);
    keys = '0;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (kv_cnt - kv0 != 1) begin
      n_err++;
      $display("FAIL hold_no_repeat: pulses=%0d expected 1", kv_cnt - kv0);
    end
  endtask

  task automatic test_entry_commit;
    int kv0, vv0;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    press(0); chk_entry("digit_1", 1, 1);
    press(1); press(2);
    press(4); chk_entry("digits_1234", 1234, 4);
    kv0 = kv_cnt;
    press(5);
    n_cmp++;
    if (kv_cnt - kv0 != 1 || last_code !== 4'd5) begin
      n_err++;
      $display("FAIL fifth_digit_pulse: pulses=%0d code=%0d expected 1 code=5", kv_cnt - kv0, last_code);
    end
    chk_entry("fifth_digit_ignored", 1234, 4);
    vv0 = vv_cnt;
    press(14);
    n_cmp++;
    if (vv_cnt - vv0 != 1 || value !== 14'd1234 || vv_cyc != kv_cyc + 1 || last_code !== 4'd15) begin
      n_err++;
      $display("FAIL commit_1234: vv_pulses=%0d value=%0d vv_lag=%0d code=%0d expected 1 1234 1 15",
               vv_cnt - vv0, value, vv_cyc - kv_cyc, last_code);
    end
    chk_entry("commit_clears", 0, 0);
  endtask

  task automatic test_backspace;
    int kv0, vv0;
    press(10); chk_entry("bs_9", 9, 1);
    press(9);  chk_entry("bs_98", 98, 2);
    press(12); chk_entry("bs_back", 9, 1);
    press(8);  chk_entry("bs_97", 97, 2);
    vv0 = vv_cnt;
    press(14);
    n_cmp++;
    if (vv_cnt - vv0 != 1 || value !== 14'd97) begin
      n_err++;
      $display("FAIL commit_97: vv_pulses=%0d value=%0d expected 1 97", vv_cnt - vv0, value);
    end
    kv0 = kv_cnt; vv0 = vv_cnt;
    press(14);
    n_cmp++;
    if (kv_cnt - kv0 != 1 || last_code !== 4'd15 || vv_cnt != vv0 || value !== 14'd97) begin
      n_err++;
      $display("FAIL empty_enter: kv=%0d code=%0d vv=%0d value=%0d expected 1 15 0 97",
               kv_cnt - kv0, last_code, vv_cnt - vv0, value);
    end
  endtask

  task automatic test_multikey_clear;
    int kv0;
    press(2); chk_entry("mk_3", 3, 1);
    kv0 = kv_cnt;
    keys = 16'h0003;
    repeat (300) @(negedge clk);
    keys = '0;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (kv_cnt != kv0) begin
      n_err++;
      $display("FAIL multikey_no_event: pulses=%0d expected 0", kv_cnt - kv0);
    end
    press(15);
    n_cmp++;
    if (kv_cnt - kv0 != 1 || last_code !== 4'd13 || value !== 14'd97) begin
      n_err++;
      $display("FAIL clear_key: pulses=%0d code=%0d value=%0d expected 1 13 97", kv_cnt - kv0, last_code, value);
    end
    chk_entry("clear_entry", 0, 0);
  endtask

  task automatic test_reset_mid;
    press(4); press(1);
    chk_entry("pre_reset_42", 42, 2);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (entry !== 14'd0 || entry_cnt !== 3'd0 || value !== 14'd0 || row !== 4'b1110) begin
      n_err++;
      $display("FAIL mid_reset: entry=%0d cnt=%0d value=%0d row=%b expected 0 0 0 1110",
               entry, entry_cnt, value, row);
    end
    rst_n = 1'b1;
    press(6);
    chk_entry("post_reset_6", 6, 1);
    n_cmp++;
    if (last_code !== 4'd6) begin
      n_err++;
      $display("FAIL post_reset_code: code=%0d expected 6", last_code);
    end
  endtask

  initial begin
    test_reset;
    test_bounce_hold;
    test_entry_commit;
    test_backspace;
    test_multikey_clear;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
